// File: rtl/request_queue_ctrl_pkg.sv
// Shared constants, result codes and FSM states for the floor request queue.
package request_queue_ctrl_pkg;
  localparam int         RQ_DEPTH = 11;
  localparam int         RQ_W     = 4;
  localparam logic [3:0] IDX_NONE = 4'hB;

  typedef enum logic [1:0] {
    RES_OK            = 2'b00,
    RES_DUPLICADO     = 2'b01,
    RES_LLENO         = 2'b10,
    RES_NO_ENCONTRADO = 2'b11
  } res_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSCAR,
    ST_ESCRIBIR,
    ST_DESPLAZAR,
    ST_FIN
  } state_t;
endpackage

// File: rtl/request_queue_ctrl_mem.sv
// DEPTH x W entry storage: one read port, a write port, a shift-down port
// (mem[j] <= mem[j+1]) and a synchronous clear of every entry.
module request_mem
  import request_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = RQ_DEPTH,
  parameter int W     = RQ_W
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic [3:0]   i_rd_idx,
  output logic [W-1:0] o_rd_data,
  input  logic         i_we,
  input  logic [3:0]   i_wr_idx,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_sh_en,
  input  logic [3:0]   i_sh_j,
  output logic [W-1:0] o_head
);
  logic [W-1:0] r_mem [DEPTH];
  logic [3:0]   w_sh_src;

  assign w_sh_src  = i_sh_j + 4'd1;
  assign o_rd_data = r_mem[i_rd_idx];
  assign o_head    = r_mem[0];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end else if (i_sh_en) begin
      r_mem[i_sh_j] <= r_mem[w_sh_src];
    end
  end
endmodule

// File: rtl/request_queue_ctrl.sv
// Floor request queue controller: FIFO of unique floor codes with a
// one-entry-per-cycle search, append on insert and shift-down on remove.
//
// state        | meaning
// ST_IDLE      | listo=1, waiting for a command (remove wins over insert)
// ST_BUSCAR    | compare entry r_idx against the operand, one per cycle
// ST_ESCRIBIR  | append operand at mem[pila], pila++
// ST_DESPLAZAR | shift entries above the match down, then clear the top
// ST_FIN       | ack pulse with resultado/indice
module request_queue_ctrl
  import request_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = RQ_DEPTH,
  parameter int W     = RQ_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] boton,
  input  logic         boton_valid,
  input  logic [W-1:0] atendido,
  input  logic         atendido_valid,
  output logic         listo,
  output logic         ack,
  output logic [1:0]   resultado,
  output logic [3:0]   indice,
  output logic [W-1:0] objetivo,
  output logic         objetivo_valid,
  output logic [3:0]   pila
);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  state_t       r_state, w_next;
  logic         r_is_rem;
  logic [W-1:0] r_opnd;
  logic [3:0]   r_idx, r_pila, r_indice;
  res_t         r_res, w_res;
  logic [3:0]   w_indice, w_wr_idx;
  logic [W-1:0] w_wr_data, w_rd_data, w_head;
  logic         w_accept, w_we, w_sh_en, w_set_res;
  logic         w_idx_inc, w_pila_inc, w_pila_dec;
  logic         w_hit, w_last;

  request_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
    .clk       (clk),
    .i_clr     (reset),
    .i_rd_idx  (r_idx),
    .o_rd_data (w_rd_data),
    .i_we      (w_we),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (w_wr_data),
    .i_sh_en   (w_sh_en),
    .i_sh_j    (r_idx),
    .o_head    (w_head)
  );

  assign w_hit  = (w_rd_data == r_opnd);
  assign w_last = (r_idx == r_pila - 4'd1);

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_we       = 1'b0;
    w_wr_idx   = r_pila;
    w_wr_data  = r_opnd;
    w_sh_en    = 1'b0;
    w_set_res  = 1'b0;
    w_res      = RES_OK;
    w_indice   = IDX_NONE;
    w_idx_inc  = 1'b0;
    w_pila_inc = 1'b0;
    w_pila_dec = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (atendido_valid || boton_valid) begin
          w_accept = 1'b1;
          if (r_pila != 4'd0) begin
            w_next = ST_BUSCAR;
          end else if (atendido_valid) begin
            w_next    = ST_FIN;
            w_set_res = 1'b1;
            w_res     = RES_NO_ENCONTRADO;
          end else begin
            w_next = ST_ESCRIBIR;
          end
        end
      end
      ST_BUSCAR: begin
        if (w_hit) begin
          // a remove keeps r_idx as the shift pointer; its result is already final
          w_set_res = 1'b1;
          w_indice  = r_idx;
          if (r_is_rem) begin
            w_next = ST_DESPLAZAR;
          end else begin
            w_next = ST_FIN;
            w_res  = RES_DUPLICADO;
          end
        end else if (w_last) begin
          if (r_is_rem) begin
            w_next    = ST_FIN;
            w_set_res = 1'b1;
            w_res     = RES_NO_ENCONTRADO;
          end else if (r_pila == DEPTH_C) begin
            w_next    = ST_FIN;
            w_set_res = 1'b1;
            w_res     = RES_LLENO;
          end else begin
            w_next = ST_ESCRIBIR;
          end
        end else begin
          w_idx_inc = 1'b1;
        end
      end
      ST_ESCRIBIR: begin
        w_we       = 1'b1;
        w_pila_inc = 1'b1;
        w_set_res  = 1'b1;
        w_indice   = r_pila;
        w_next     = ST_FIN;
      end
      ST_DESPLAZAR: begin
        if (w_last) begin
          w_we       = 1'b1;
          w_wr_idx   = r_idx;
          w_wr_data  = '0;
          w_pila_dec = 1'b1;
          w_next     = ST_FIN;
        end else begin
          w_sh_en   = 1'b1;
          w_idx_inc = 1'b1;
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_is_rem <= 1'b0;
      r_opnd   <= '0;
      r_idx    <= 4'd0;
      r_pila   <= 4'd0;
      r_res    <= RES_OK;
      r_indice <= IDX_NONE;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_is_rem <= atendido_valid;
        r_opnd   <= atendido_valid ? atendido : boton;
        r_idx    <= 4'd0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 4'd1;
      end
      if (w_pila_inc)      r_pila <= r_pila + 4'd1;
      else if (w_pila_dec) r_pila <= r_pila - 4'd1;
      if (w_set_res) begin
        r_res    <= w_res;
        r_indice <= w_indice;
      end
    end
  end

  assign listo          = (r_state == ST_IDLE) && !reset;
  assign ack            = (r_state == ST_FIN) && !reset;
  assign resultado      = reset ? 2'b00 : r_res;
  assign indice         = reset ? IDX_NONE : r_indice;
  assign objetivo       = reset ? '0 : w_head;
  assign objetivo_valid = (r_pila != 4'd0) && !reset;
  assign pila           = r_pila;
endmodule

// File: doc/request_queue_ctrl.md
REQUEST_QUEUE_CTRL -- requirements
Module: request_queue_ctrl

Interface
REQ-001 Parameter DEPTH, default 11: number of request entries, indices 0..DEPTH-1.
REQ-002 Parameter W, default 4: floor code width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 boton  in  W  floor code to insert.
REQ-007 boton_valid  in  1  insert request.
REQ-008 atendido  in  W  floor code to remove (floor served).
REQ-009 atendido_valid  in  1  remove request.
REQ-010 listo  out  1  high only in IDLE; a command is accepted on any edge where listo=1 and a valid is high.
REQ-011 ack  out  1  one-cycle pulse marking command completion.
REQ-012 resultado  out  2  status, valid when ack=1: 00 OK, 01 DUPLICADO, 10 LLENO, 11 NO_ENCONTRADO.
REQ-013 indice  out  4  matched or written index, valid when ack=1; 11 (4'hB) when there is no index.
REQ-014 objetivo  out  W  entry 0, the next target floor; 0 when the queue is empty.
REQ-015 objetivo_valid  out  1  high when pila>0.
REQ-016 pila  out  4  occupied entry count, 0..DEPTH.

Function
REQ-017 States: IDLE, BUSCAR, ESCRIBIR, DESPLAZAR, FIN.
REQ-018 Acceptance: both valids high in IDLE -> remove wins; the insert is not accepted, and the requester SHALL hold boton_valid.
REQ-019 On acceptance: latch the operand and the operation; go to BUSCAR if pila>0, otherwise to FIN.
 - Insert with pila=0 -> FIN via ESCRIBIR.
 - Remove with pila=0 -> FIN with NO_ENCONTRADO.
REQ-020 BUSCAR compares exactly one entry per cycle, idx = 0, 1, ...
 - Match -> latch idx and leave.
 - idx=pila-1 with no match -> not found.
 - Worst case: pila cycles.
REQ-021 Insert, match -> FIN, DUPLICADO, indice=idx.
REQ-022 Insert, no match, pila=DEPTH -> FIN, LLENO, indice=11.
REQ-023 Insert, no match, pila<DEPTH -> ESCRIBIR: mem[pila]<=boton, pila increments, indice=old pila; then FIN, OK.
REQ-024 Remove, no match -> FIN, NO_ENCONTRADO, indice=11.
REQ-025 Remove, match at k -> DESPLAZAR.
 - One cycle per step: mem[j]<=mem[j+1] for j=k..pila-2.
 - Final cycle: mem[pila-1]<=0, pila decrements.
 - k=pila-1: one cycle, clear only.
 - Then FIN, OK, indice=k.
REQ-026 FIN lasts one cycle: ack=1, then IDLE, listo=1 on the next cycle.
REQ-027 Inputs are ignored while listo=0.
REQ-028 Queue order is FIFO by insertion; entries 0..pila-1 stay contiguous, entries >=pila read 0.
REQ-029 pila never exceeds DEPTH and never underflows.
REQ-030 objetivo and objetivo_valid are registered and reflect mem[0] and pila after each edge.

Reset
REQ-031 reset=1 at an edge, from any state, SHALL:
 - set the state to IDLE, pila=0 and all mem entries to 0;
 - drive ack=0, resultado=00, indice=11, objetivo=0, objetivo_valid=0 and listo=0 during reset.
REQ-032 listo=1 on the first edge after reset deasserts.
REQ-033 Reset mid-operation aborts the command: no ack and no partial write remain.

Structure
REQ-034 A shared package SHALL hold:
 - DEPTH, W and the not-found index constant 11;
 - the resultado codes;
 - the state enumeration.
REQ-035 One sub-module, request_mem, SHALL contain:
 - the DEPTH x W register file;
 - a single read port (idx), a write port, a shift-down port (j) and a synchronous clear.
REQ-036 Control, counters and status live in request_queue_ctrl.

Verification
REQ-037 After reset:
 - insert 5 -> ack after 2 cycles (FIN), OK, indice=0, objetivo=5, pila=1.
 - Insert 5 again -> DUPLICADO, indice=0, pila=1.
REQ-038 Insert 0..10 -> pila=11, each ack OK. Then insert 12 -> ack after 11 BUSCAR cycles, LLENO, indice=11, contents unchanged.
REQ-039 Queue [3,7,9,2]:
 - remove 7 -> OK, indice=1, queue [3,9,2,0..], pila=3, DESPLAZAR lasts 3 cycles.
 - remove 4 -> NO_ENCONTRADO, indice=11.
REQ-040 boton_valid (8) and atendido_valid (3) both high in IDLE with queue [3] -> remove done first (pila=0, objetivo_valid=0), then insert 8 -> OK, objetivo=8.
REQ-041 Queue of 6 entries, remove of mem[0] started, reset asserted at the 2nd DESPLAZAR cycle -> no ack, pila=0, all entries 0, listo=1 one cycle after reset release.
